// File: rtl/keyboard_pkg.sv
// ============================================================================
// Module   : keyboard_pkg
// Brief    : Shared types and default sizes for the keyboard voice allocator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keyboard_pkg;

    localparam int c_NUM_VOICES = 3;
    localparam int c_PRD_W      = 32;
    localparam int c_KEY_W      = 6;
    localparam int c_AGE_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

    typedef struct packed {
        logic               on;
        logic [c_KEY_W-1:0] key;
        logic [c_PRD_W-1:0] period;
    } key_event_t;

endpackage

`default_nettype wire

// File: rtl/voice_slot.sv
// ============================================================================
// Module   : voice_slot
// Brief    : One oscillator voice record: key, period, busy flag, age.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_slot #(
    parameter int PRD_W = 32,
    parameter int KEY_W = 6,
    parameter int AGE_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_age_inc,
    input  logic [KEY_W-1:0] i_key,
    input  logic [PRD_W-1:0] i_prd,
    output logic [KEY_W-1:0] o_key,
    output logic [PRD_W-1:0] o_prd,
    output logic             o_active,
    output logic [AGE_W-1:0] o_age
);

    localparam logic [AGE_W-1:0] c_AGE_MAX = '1;

    logic [KEY_W-1:0] r_key;
    logic [PRD_W-1:0] r_prd;
    logic             r_active;
    logic [AGE_W-1:0] r_age;

    // Load wins over age_inc so a freshly (re)triggered voice restarts at age 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key    <= '0;
            r_prd    <= '0;
            r_active <= 1'b0;
            r_age    <= '0;
        end else if (i_load) begin
            r_key    <= i_key;
            r_prd    <= i_prd;
            r_active <= 1'b1;
            r_age    <= '0;
        end else if (i_clear) begin
            r_key    <= '0;
            r_prd    <= '0;
            r_active <= 1'b0;
            r_age    <= '0;
        end else if (i_age_inc && r_active && (r_age != c_AGE_MAX)) begin
            r_age    <= r_age + 1'b1;
        end
    end

    assign o_key    = r_key;
    assign o_prd    = r_prd;
    assign o_active = r_active;
    assign o_age    = r_age;

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================================
// Module   : voice_allocator
// Brief    : Scan-then-commit key event allocator over NUM_VOICES voice slots.
//            Define VOICE_STEAL_EN to steal the oldest voice when all are busy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_allocator
    import keyboard_pkg::*;
#(
    parameter int NUM_VOICES = c_NUM_VOICES,
    parameter int PRD_W      = c_PRD_W,
    parameter int KEY_W      = c_KEY_W,
    parameter int AGE_W      = c_AGE_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_on,
    input  logic [KEY_W-1:0]              ev_key,
    input  logic [PRD_W-1:0]              ev_period,
    output logic [NUM_VOICES*PRD_W-1:0]   voice_prd,
    output logic [NUM_VOICES-1:0]         voice_active,
    output logic [$clog2(NUM_VOICES+1)-1:0] notes,
    output logic                          drop_pulse,
    output logic                          steal_pulse
);

    localparam int c_IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int c_CNT_W = $clog2(NUM_VOICES + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_VOICES - 1);

    alloc_state_t r_state;
    alloc_state_t w_state_nxt;

    logic               r_ev_on;
    logic [KEY_W-1:0]   r_ev_key;
    logic [PRD_W-1:0]   r_ev_prd;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_match_found;
    logic [c_IDX_W-1:0] r_match_idx;
    logic               r_free_found;
    logic [c_IDX_W-1:0] r_free_idx;
    logic [c_CNT_W-1:0] r_notes;
    logic               r_drop_pulse;

    logic [KEY_W-1:0]      w_slot_key [NUM_VOICES];
    logic [PRD_W-1:0]      w_slot_prd [NUM_VOICES];
    logic [AGE_W-1:0]      w_slot_age [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_slot_active;
    logic [NUM_VOICES-1:0] w_load;
    logic [NUM_VOICES-1:0] w_clear;
    logic [NUM_VOICES-1:0] w_age_inc;
    logic [NUM_VOICES-1:0] w_next_active;
    logic [c_CNT_W-1:0]    w_notes_nxt;
    logic                  w_drop;
    logic                  w_is_on;
    logic                  w_cur_active;
    logic [KEY_W-1:0]      w_cur_key;
    logic                  w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
            voice_slot #(
                .PRD_W (PRD_W),
                .KEY_W (KEY_W),
                .AGE_W (AGE_W)
            ) u_slot (
                .clk       (clk),
                .reset_n   (reset_n),
                .i_load    (w_load[gi]),
                .i_clear   (w_clear[gi]),
                .i_age_inc (w_age_inc[gi]),
                .i_key     (r_ev_key),
                .i_prd     (r_ev_prd),
                .o_key     (w_slot_key[gi]),
                .o_prd     (w_slot_prd[gi]),
                .o_active  (w_slot_active[gi]),
                .o_age     (w_slot_age[gi])
            );
            assign voice_prd[gi*PRD_W +: PRD_W] = w_slot_prd[gi];
        end
    endgenerate

    assign voice_active = w_slot_active;
    assign ev_ready     = (r_state == IDLE);
    assign w_accept     = ev_valid && ev_ready;
    assign w_cur_active = w_slot_active[r_idx];
    assign w_cur_key    = w_slot_key[r_idx];
    // A key-on with zero period is treated as a release of that key.
    assign w_is_on      = r_ev_on && (r_ev_prd != '0);

`ifdef VOICE_STEAL_EN
    logic [c_IDX_W-1:0] r_old_idx;
    logic [AGE_W-1:0]   r_old_age;
    logic               r_steal_pulse;
    logic               w_steal;
    logic [AGE_W-1:0]   w_cur_age;

    assign w_cur_age   = w_slot_age[r_idx];
    assign steal_pulse = r_steal_pulse;
`else
    logic w_unused_age;

    assign w_unused_age = ^{w_slot_age};
    assign steal_pulse  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = '0;
        w_clear     = '0;
        w_age_inc   = '0;
        w_drop      = 1'b0;
`ifdef VOICE_STEAL_EN
        w_steal     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (ev_valid) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (r_idx == c_LAST_IDX) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                w_state_nxt = IDLE;
                if (w_is_on) begin
                    if (r_match_found) begin
                        w_load[r_match_idx] = 1'b1;
                        w_age_inc           = '1;
                    end else if (r_free_found) begin
                        w_load[r_free_idx]  = 1'b1;
                        w_age_inc           = '1;
                    end else begin
`ifdef VOICE_STEAL_EN
                        w_load[r_old_idx]   = 1'b1;
                        w_age_inc           = '1;
                        w_steal             = 1'b1;
`else
                        w_drop              = 1'b1;
`endif
                    end
                end else if (r_match_found) begin
                    w_clear[r_match_idx] = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_next_active = (w_slot_active | w_load) & ~w_clear;

    always_comb begin
        w_notes_nxt = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_notes_nxt = w_notes_nxt + c_CNT_W'(w_next_active[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ev_on       <= 1'b0;
            r_ev_key      <= '0;
            r_ev_prd      <= '0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_notes       <= '0;
            r_drop_pulse  <= 1'b0;
        end else begin
            r_notes      <= w_notes_nxt;
            r_drop_pulse <= w_drop;
            if (w_accept) begin
                r_ev_on       <= ev_on;
                r_ev_key      <= ev_key;
                r_ev_prd      <= ev_period;
                r_idx         <= '0;
                r_match_found <= 1'b0;
                r_free_found  <= 1'b0;
            end else if (r_state == SCAN) begin
                if (!r_match_found && w_cur_active && (w_cur_key == r_ev_key)) begin
                    r_match_found <= 1'b1;
                    r_match_idx   <= r_idx;
                end
                if (!r_free_found && !w_cur_active) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_idx;
                end
                if (r_idx != c_LAST_IDX) r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Strict '>' keeps the lowest index on age ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_steal_pulse <= 1'b0;
        end else begin
            r_steal_pulse <= w_steal;
            if ((r_state == SCAN) && ((r_idx == '0) || (w_cur_age > r_old_age))) begin
                r_old_idx <= r_idx;
                r_old_age <= w_cur_age;
            end
        end
    end
`endif

    assign notes      = r_notes;
    assign drop_pulse = r_drop_pulse;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// Module   : tb_voice_allocator
// Brief    : Directed self-checking bench for voice_allocator (3 voices).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_allocator;
    import keyboard_pkg::*;

    localparam int NV = 3;
    localparam int PW = 32;
    localparam int KW = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [KW-1:0]     ev_key;
    logic [PW-1:0]     ev_period;
    logic [NV*PW-1:0]  voice_prd;
    logic [NV-1:0]     voice_active;
    logic [1:0]        notes;
    logic              drop_pulse;
    logic              steal_pulse;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    voice_allocator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_key       (ev_key),
        .ev_period    (ev_period),
        .voice_prd    (voice_prd),
        .voice_active (voice_active),
        .notes        (notes),
        .drop_pulse   (drop_pulse),
        .steal_pulse  (steal_pulse)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [95:0] e_prd, input logic [2:0] e_act,
                             input logic [1:0] e_notes, input logic e_drop, input logic e_steal);
        check({tag, ".prd"},    voice_prd,    e_prd);
        check({tag, ".active"}, voice_active, e_act);
        check({tag, ".notes"},  notes,        e_notes);
        check({tag, ".drop"},   drop_pulse,   e_drop);
        check({tag, ".steal"},  steal_pulse,  e_steal);
        check({tag, ".ready"},  ev_ready,     1'b1);
    endtask

    function automatic key_event_t mk(input logic on, input logic [KW-1:0] key, input logic [PW-1:0] prd);
        key_event_t e;
        e.on = on;
        e.key = key;
        e.period = prd;
        return e;
    endfunction

    // Returns sampled #1 after the commit edge, i.e. in the cycle the results appear.
    task automatic send(input key_event_t e);
        int guard = 0;
        @(negedge clk);
        while (!ev_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_timeout", guard < 50, 1'b1);
        ev_valid  = 1'b1;
        ev_on     = e.on;
        ev_key    = e.key;
        ev_period = e.period;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("busy_at_commit", ev_ready, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulses_gone(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".drop_clr"},  drop_pulse,  1'b0);
        check({tag, ".steal_clr"}, steal_pulse, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        ev_valid  = 1'b0;
        ev_on     = 1'b0;
        ev_key    = '0;
        ev_period = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 check_all("reset", '0, 3'b000, 2'd0, 1'b0, 1'b0);

        // Basic allocation latency
        send(mk(1'b1, 6'd5, 32'd1000));
        check_all("t1", {32'd0, 32'd0, 32'd1000}, 3'b001, 2'd1, 1'b0, 1'b0);

        // Fill all voices, then overflow
        do_reset();
        send(mk(1'b1, 6'd1, 32'd10));
        send(mk(1'b1, 6'd2, 32'd20));
        send(mk(1'b1, 6'd3, 32'd30));
        check_all("t2.fill", {32'd30, 32'd20, 32'd10}, 3'b111, 2'd3, 1'b0, 1'b0);
        send(mk(1'b1, 6'd4, 32'd40));
`ifdef VOICE_STEAL_EN
        check_all("t2.steal", {32'd30, 32'd20, 32'd40}, 3'b111, 2'd3, 1'b0, 1'b1);
`else
        check_all("t2.drop", {32'd30, 32'd20, 32'd10}, 3'b111, 2'd3, 1'b1, 1'b0);
`endif
        pulses_gone("t2");

        // Release a held key, then release an unknown key
        send(mk(1'b0, 6'd2, 32'd0));
`ifdef VOICE_STEAL_EN
        check_all("t4.off", {32'd30, 32'd0, 32'd40}, 3'b101, 2'd2, 1'b0, 1'b0);
`else
        check_all("t4.off", {32'd30, 32'd0, 32'd10}, 3'b101, 2'd2, 1'b0, 1'b0);
`endif
        send(mk(1'b0, 6'd9, 32'd0));
`ifdef VOICE_STEAL_EN
        check_all("t4.nomatch", {32'd30, 32'd0, 32'd40}, 3'b101, 2'd2, 1'b0, 1'b0);
`else
        check_all("t4.nomatch", {32'd30, 32'd0, 32'd10}, 3'b101, 2'd2, 1'b0, 1'b0);
`endif

        // Freed voice reused, then a second overflow picks the oldest (voice 2)
        send(mk(1'b1, 6'd6, 32'd60));
        send(mk(1'b1, 6'd8, 32'd80));
`ifdef VOICE_STEAL_EN
        check_all("t2.steal2", {32'd80, 32'd60, 32'd40}, 3'b111, 2'd3, 1'b0, 1'b1);
`else
        check_all("t2.drop2", {32'd30, 32'd60, 32'd10}, 3'b111, 2'd3, 1'b1, 1'b0);
`endif
        pulses_gone("t2b");

        // Retrigger of a held key
        do_reset();
        send(mk(1'b1, 6'd7, 32'd50));
        send(mk(1'b1, 6'd7, 32'd60));
        check_all("t3.retrig", {32'd0, 32'd0, 32'd60}, 3'b001, 2'd1, 1'b0, 1'b0);

        // Key-on with zero period frees the voice
        send(mk(1'b1, 6'd3, 32'd30));
        check_all("t6.alloc", {32'd0, 32'd30, 32'd60}, 3'b011, 2'd2, 1'b0, 1'b0);
        send(mk(1'b1, 6'd3, 32'd0));
        check_all("t6.zero", {32'd0, 32'd0, 32'd60}, 3'b001, 2'd1, 1'b0, 1'b0);

        // ev_valid held high: accepted every NV+2 cycles
        @(negedge clk);
        ev_valid  = 1'b1;
        ev_on     = 1'b1;
        ev_key    = 6'd10;
        ev_period = 32'd11;
        check("hold.ready0", ev_ready, 1'b1);
        for (int e = 0; e < 2; e++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("hold.busy", ev_ready, 1'b0);
            end
            @(negedge clk);
            check("hold.ready", ev_ready, 1'b1);
        end
        ev_valid = 1'b0;
        check("hold.prd",   voice_prd, {32'd0, 32'd11, 32'd60});
        check("hold.notes", notes,     2'd2);

        // Reset asserted in the middle of a scan
        @(negedge clk);
        ev_valid  = 1'b1;
        ev_on     = 1'b1;
        ev_key    = 6'd12;
        ev_period = 32'd99;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5.prd",    voice_prd,    '0);
        check("t5.active", voice_active, 3'b000);
        check("t5.notes",  notes,        2'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("t5.nodrop",  drop_pulse,  1'b0);
            check("t5.nosteal", steal_pulse, 1'b0);
        end
        check_all("t5.after", '0, 3'b000, 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
